// File: rtl/vga_pkg.sv
// vga_pkg: shared 640x480@60 timing, matrix grid geometry and colour constants.
// Holds no ports. It provides the cell_of/on_line helpers that map a counter
// value onto grid cells without using dividers.
package vga_pkg;
    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;
    localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int CNT_W     = 11;
    localparam int N         = 4;
    localparam int CELL_W    = 160;
    localparam int CELL_H    = 120;
    localparam int DATA_W    = 8;
    localparam int RGB_W     = 4;
    localparam int CELLS     = N * N;
    localparam int IDX_W     = $clog2(CELLS);
    localparam int RC_W      = $clog2(N);
    localparam logic [3*RGB_W-1:0] GRID_RGB = 12'hFFF;
    localparam logic [3*RGB_W-1:0] ZERO_RGB = 12'h002;

    // Largest cell index whose left/top edge is at or before pos, clamped to N-1.
    function automatic logic [RC_W-1:0] cell_of(input logic [CNT_W-1:0] pos, input int size);
        cell_of = '0;
        for (int c = 1; c < N; c++)
            if (pos >= CNT_W'(c * size)) cell_of = RC_W'(c);
    endfunction

    // True when pos sits exactly on a cell's leading edge.
    function automatic logic on_line(input logic [CNT_W-1:0] pos, input int size);
        on_line = 1'b0;
        for (int c = 0; c < N; c++)
            if (pos == CNT_W'(c * size)) on_line = 1'b1;
    endfunction
endpackage

// File: rtl/matrix_pingpong_buf.sv
// matrix_pingpong_buf: ping-pong matrix store with a valid/ready load port and a vblank-aligned swap.
// Ports: clk/reset (async, active high); clk_en/vblank_in qualify the swap edge;
// ld_valid/ld_ready/ld_data/ld_last form the load port; rd_row/rd_col -> rd_data
// is a combinational read of the display bank; frame_swap pulses on a swap;
// load_err is a sticky ld_last protocol error flag.
module matrix_pingpong_buf
    import vga_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_en,
    input  logic              vblank_in,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    input  logic [RC_W-1:0]   rd_row,
    input  logic [RC_W-1:0]   rd_col,
    output logic [DATA_W-1:0] rd_data,
    output logic              frame_swap,
    output logic              load_err
);
    logic [DATA_W-1:0] bank_q [2][CELLS];
    logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
    logic disp_sel_q, disp_sel_d, shadow_full_q, shadow_full_d, err_q, err_d;
    logic ready_q, vblank_q, swap_q, accept, at_end, swap;

    always_comb begin
        accept        = ld_valid && ready_q;
        at_end        = wr_idx_q == IDX_W'(CELLS - 1);
        // shadow_full_q is the registered flag, so a matrix that completes on the edge itself waits a frame
        swap          = clk_en && vblank_in && !vblank_q && shadow_full_q;
        disp_sel_d    = disp_sel_q ^ swap;
        shadow_full_d = swap ? 1'b0 : (shadow_full_q | (accept && at_end));
        // an early ld_last rewinds the write pointer, discarding the partial matrix
        wr_idx_d      = (swap || (accept && (at_end || ld_last))) ? '0 : wr_idx_q + IDX_W'(accept);
        err_d         = err_q | (accept && (ld_last != at_end));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int b = 0; b < 2; b++)
                for (int i = 0; i < CELLS; i++)
                    bank_q[b][i] <= '0;
            wr_idx_q      <= '0;
            disp_sel_q    <= 1'b0;
            shadow_full_q <= 1'b0;
            err_q         <= 1'b0;
            ready_q       <= 1'b0;
            vblank_q      <= 1'b0;
            swap_q        <= 1'b0;
        end else begin
            if (accept) bank_q[!disp_sel_q][wr_idx_q] <= ld_data;
            wr_idx_q      <= wr_idx_d;
            disp_sel_q    <= disp_sel_d;
            shadow_full_q <= shadow_full_d;
            err_q         <= err_d;
            // registered so ready stays low through reset and rises on the first clk after release
            ready_q       <= !shadow_full_d;
            swap_q        <= swap;
            if (clk_en) vblank_q <= vblank_in;
        end
    end

    assign ld_ready   = ready_q;
    assign rd_data    = bank_q[disp_sel_q][IDX_W'(rd_row) * IDX_W'(N) + IDX_W'(rd_col)];
    assign frame_swap = swap_q;
    assign load_err   = err_q;
endmodule

// File: rtl/matrix_frame_renderer.sv
// matrix_frame_renderer: renders a 4x4 matrix as a VGA cell grid behind a two-stage pixel pipeline.
// Ports: clk/reset (async, active high); clk_en is the pixel-rate enable;
// h_count/v_count and the sync/blank inputs come from the timing counters;
// ld_* is the matrix load port; vga_* carries the colour and syncs, both
// delayed by 2 enabled cycles; frame_swap and load_err come from the buffer.
module matrix_frame_renderer
    import vga_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_en,
    input  logic [CNT_W-1:0]  h_count,
    input  logic [CNT_W-1:0]  v_count,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic              hblank_in,
    input  logic              vblank_in,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic [RGB_W-1:0]  vga_r,
    output logic [RGB_W-1:0]  vga_g,
    output logic [RGB_W-1:0]  vga_b,
    output logic              vga_hsync,
    output logic              vga_vsync,
    output logic              frame_swap,
    output logic              load_err
);
    logic [RC_W-1:0]    row_q, col_q, row_d, col_d;
    logic               grid_q, grid_d, blank_q, hs1_q, vs1_q, hs2_q, vs2_q;
    logic [3*RGB_W-1:0] rgb_q, rgb_d;
    logic [DATA_W-1:0]  elem;

    matrix_pingpong_buf u_buf (
        .clk        (clk),
        .reset      (reset),
        .clk_en     (clk_en),
        .vblank_in  (vblank_in),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_data    (ld_data),
        .ld_last    (ld_last),
        .rd_row     (row_q),
        .rd_col     (col_q),
        .rd_data    (elem),
        .frame_swap (frame_swap),
        .load_err   (load_err)
    );

    always_comb begin
        col_d  = cell_of(h_count, CELL_W);
        row_d  = cell_of(v_count, CELL_H);
        grid_d = on_line(h_count, CELL_W) || on_line(v_count, CELL_H);
        rgb_d  = blank_q ? '0 : grid_q ? GRID_RGB : (elem == '0) ? ZERO_RGB : {3{elem[DATA_W-1 -: RGB_W]}};
    end

    // S1 resets to a blanked pixel so the first enabled cycles after reset stay black with syncs idle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_q   <= '0;
            col_q   <= '0;
            grid_q  <= 1'b0;
            blank_q <= 1'b1;
            hs1_q   <= 1'b1;
            vs1_q   <= 1'b1;
            rgb_q   <= '0;
            hs2_q   <= 1'b1;
            vs2_q   <= 1'b1;
        end else if (clk_en) begin
            row_q   <= row_d;
            col_q   <= col_d;
            grid_q  <= grid_d;
            blank_q <= hblank_in | vblank_in;
            hs1_q   <= hsync_in;
            vs1_q   <= vsync_in;
            rgb_q   <= rgb_d;
            hs2_q   <= hs1_q;
            vs2_q   <= vs1_q;
        end
    end

    assign {vga_r, vga_g, vga_b} = rgb_q;
    assign vga_hsync = hs2_q;
    assign vga_vsync = vs2_q;
endmodule

// File: tb/tb_matrix_frame_renderer.sv
// tb_matrix_frame_renderer: randomized scoreboard bench for matrix_frame_renderer.
module tb_matrix_frame_renderer;
    import vga_pkg::*;

    logic clk = 0, reset = 1, clk_en = 0;
    logic hsync_in = 1, vsync_in = 1, hblank_in = 0, vblank_in = 0;
    logic ld_valid = 0, ld_last = 0;
    logic [10:0] h_count = 0, v_count = 0;
    logic [7:0]  ld_data = 0;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic vga_hsync, vga_vsync, ld_ready, frame_swap, load_err;

    always #5 clk = ~clk;

    matrix_frame_renderer dut (
        .clk(clk), .reset(reset), .clk_en(clk_en),
        .h_count(h_count), .v_count(v_count),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .hblank_in(hblank_in), .vblank_in(vblank_in),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
        .frame_swap(frame_swap), .load_err(load_err)
    );

    typedef logic [13:0] exp_t;
    typedef struct packed { logic [7:0] d; logic last; } ld_t;

    int tests = 0, fails = 0, swaps = 0;
    exp_t sb[$];
    exp_t hold_exp;
    ld_t  ldq[$];
    int   ld_rate = 100;

    // reference: the displayed matrix is the last complete one at the most recent swap
    logic [7:0] m_disp[16], m_shadow[16];
    int m_idx;
    bit m_full, m_ready, m_err, m_vbprev, m_swap;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t pix(input int h, input int v, input bit hs, input bit vs);
        logic [11:0] rgb;
        logic [7:0]  e;
        if (h >= 640 || v >= 480) rgb = 12'h000;
        else if (h % 160 == 0 || v % 120 == 0) rgb = 12'hFFF;
        else begin
            e   = m_disp[(v / 120) * 4 + h / 160];
            rgb = (e == 0) ? 12'h002 : {e[7:4], e[7:4], e[7:4]};
        end
        return {rgb, hs, vs};
    endfunction

    function automatic int rand_h();
        int hl[11] = '{0, 1, 159, 160, 161, 319, 320, 480, 639, 640, 799};
        return ($urandom % 4 == 0) ? hl[$urandom % 11] : int'($urandom % 800);
    endfunction

    function automatic int rand_v();
        int vl[7] = '{0, 119, 120, 121, 240, 360, 479};
        return ($urandom % 4 == 0) ? vl[$urandom % 7] : int'($urandom % 480);
    endfunction

    task automatic push_ld(input logic [7:0] d, input bit last);
        ld_t t;
        t.d = d;
        t.last = last;
        ldq.push_back(t);
    endtask

    task automatic cyc(input int h, input int v, input bit en);
        bit hs, vs, vb, acc, swp;
        ld_t it;
        @(negedge clk);
        hs = 1'($urandom);
        vs = 1'($urandom);
        vb = v >= 480;
        h_count = 11'(h); v_count = 11'(v);
        hsync_in = hs; vsync_in = vs;
        hblank_in = h >= 640; vblank_in = vb;
        clk_en = en;
        it.d = 8'($urandom);
        it.last = 1'b0;
        if (ldq.size() > 0) it = ldq[0];
        ld_valid = ldq.size() > 0 && ($urandom % 100 < ld_rate);
        ld_data = it.d;
        ld_last = it.last;
        check("ld_ready", ld_ready, m_ready);
        acc = ld_valid && m_ready;
        swp = en && vb && !m_vbprev && m_full;
        if (en) sb.push_back(pix(h, v, hs, vs));
        if (acc) begin
            void'(ldq.pop_front());
            m_shadow[m_idx] = it.d;
            if (it.last != (m_idx == 15)) m_err = 1;
            if (m_idx == 15) begin m_full = 1; m_idx = 0; end
            else if (it.last) m_idx = 0;
            else m_idx++;
        end
        if (swp) begin m_disp = m_shadow; m_full = 0; m_idx = 0; end
        if (en) m_vbprev = vb;
        m_swap = swp;
        m_ready = !m_full;
        @(posedge clk);
        #1;
        check("frame_swap", frame_swap, m_swap);
        check("load_err", load_err, m_err);
        if (frame_swap === 1'b1) swaps++;
    endtask

    task automatic run(input int n, input int per, input bit vbl);
        for (int i = 0; i < n; i++) cyc(rand_h(), vbl ? 480 + int'($urandom % 45) : rand_v(), (i % per) == 0);
    endtask

    task automatic do_reset();
        reset = 1;
        clk_en = 0;
        ld_valid = 0;
        sb.delete();
        ldq.delete();
        sb.push_back({12'h000, 2'b11});
        hold_exp = {12'h000, 2'b11};
        foreach (m_disp[i]) begin m_disp[i] = 0; m_shadow[i] = 0; end
        m_idx = 0; m_full = 0; m_err = 0; m_vbprev = 0; m_swap = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 0;
        #1 check("ready_after_release", ld_ready, 0);
        m_ready = 1;
    endtask

    task automatic mid_reset();
        @(negedge clk);
        #2 reset = 1;
        #1;
        check("rst_rgb", {vga_r, vga_g, vga_b}, 0);
        check("rst_syncs", {vga_hsync, vga_vsync}, 2'b11);
        check("rst_ready", ld_ready, 0);
        check("rst_swap", frame_swap, 0);
        check("rst_err", load_err, 0);
        do_reset();
    endtask

    // monitor: every enabled edge presents a new pixel, every other edge must hold the last one
    initial forever begin
        bit en;
        @(posedge clk);
        en = clk_en;
        #1;
        if (!reset) begin
            if (en) begin
                if (sb.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL scoreboard: pixel with no expectation queued");
                end else hold_exp = sb.pop_front();
            end
            check("pixel", {vga_r, vga_g, vga_b, vga_hsync, vga_vsync}, hold_exp);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int s0;
        do_reset();
        // empty matrix: grid plus 002 fill, no swap on vblank
        run(200, 1, 0); run(4, 1, 1); run(100, 1, 0);
        check("no_swap_empty", swaps, 0);
        // mid-frame load becomes visible only after the vblank edge
        ld_rate = 70;
        for (int i = 0; i < 16; i++) push_ld(8'(8'h10 + i), i == 15);
        run(150, 1, 0);
        check("ready_when_full", ld_ready, 0);
        check("no_swap_before_vblank", swaps, 0);
        run(3, 1, 1);
        check("swap_once", swaps, 1);
        cyc(200, 130, 1); cyc(200, 130, 1); cyc(200, 130, 1);
        check("pixel_200_130", {vga_r, vga_g, vga_b}, 12'h111);
        run(100, 1, 0);
        // final accept coincides with the vblank edge
        ld_rate = 100;
        for (int i = 0; i < 15; i++) push_ld(8'($urandom), 0);
        for (int g = 0; g < 100 && ldq.size() > 0; g++) cyc(rand_h(), rand_v(), 1);
        check("drain", ldq.size(), 0);
        push_ld(8'h5A, 1);
        s0 = swaps;
        cyc(300, 480, 1);
        check("same_clk_no_swap", swaps, s0);
        run(3, 1, 1); run(40, 1, 0); run(3, 1, 1);
        check("same_clk_next_frame", swaps, s0 + 1);
        run(60, 1, 0);
        // early ld_last on element 7 then a clean matrix
        ld_rate = 60;
        for (int i = 0; i < 8; i++) push_ld(8'($urandom), i == 7);
        for (int i = 0; i < 16; i++) push_ld(($urandom % 5 == 0) ? 8'h00 : 8'($urandom), i == 15);
        run(120, 1, 0);
        check("err_sticky", load_err, 1);
        s0 = swaps;
        run(2, 1, 1);
        check("swap_after_err", swaps, s0 + 1);
        run(150, 1, 0);
        // clk_en 1-in-4 with a load in flight
        for (int i = 0; i < 16; i++) push_ld(8'($urandom), i == 15);
        run(240, 4, 0); run(12, 4, 1); run(240, 4, 0);
        // reset mid-load and mid-frame
        ld_rate = 100;
        for (int i = 0; i < 16; i++) push_ld(8'hE0 + 8'(i), i == 15);
        run(5, 1, 0);
        mid_reset();
        s0 = swaps;
        run(100, 1, 0); run(3, 1, 1); run(100, 1, 0);
        check("no_swap_after_reset", swaps, s0);
        check("err_clear_after_reset", load_err, 0);
        repeat (3) cyc(rand_h(), rand_v(), 1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/matrix_frame_renderer.md
Name: matrix_frame_renderer

Overview:
Pixel stage placed directly downstream of the horizontal and vertical timing counters. It maps each (h_count, v_count) position onto a 4x4 grid of matrix cells and renders each cell's element value as a 4-bit-per-channel VGA colour. It delays hsync and vsync to match the pixel pipeline. Matrix results arrive over a valid/ready load port into a ping-pong buffer, and the buffers swap only at the start of vertical blanking, so no frame ever shows a partially loaded matrix.

Parameters:
H_VISIBLE, 640, visible pixels per line
V_VISIBLE, 480, visible lines per frame
N, 4, matrix dimension; grid is N x N cells
CELL_W, 160, cell width in pixels; N*CELL_W must equal H_VISIBLE
CELL_H, 120, cell height in lines; N*CELL_H must equal V_VISIBLE
DATA_W, 8, element width; minimum 4

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
clk_en  in  1  pixel-rate enable; the pixel pipeline advances only when clk_en=1
h_count  in  11  horizontal position from the horizontal counter
v_count  in  11  vertical position from vertical_counter
hsync_in  in  1  active-low hsync aligned with h_count
vsync_in  in  1  active-low vsync aligned with v_count
hblank_in  in  1  high outside the visible columns
vblank_in  in  1  high outside the visible lines
ld_valid  in  1  load element valid
ld_ready  out  1  load element accepted when ld_valid && ld_ready
ld_data  in  DATA_W  element value; row-major order, index 0..N*N-1
ld_last  in  1  marks the final element of a matrix
vga_r, vga_g, vga_b  out  4 each  pixel colour
vga_hsync, vga_vsync  out  1 each  delayed syncs, active-low
frame_swap  out  1  one-clk pulse on a buffer swap
load_err  out  1  sticky ld_last protocol error flag

Behaviour:
- Reset (async, active-high) state:
  - both banks cleared to 0; disp_sel=0; wr_idx=0; shadow_full=0
  - RGB=0; vga_hsync=1; vga_vsync=1; frame_swap=0; load_err=0
  - ld_ready drops to 0 during reset and rises in the first clk after release.
  - A reset asserted mid-frame or mid-load discards all state. No partial matrix survives.
- Load port:
  - Runs on every clk and is not gated by clk_en.
  - ld_ready = !shadow_full.
  - Each accepted element is written into shadow bank (!disp_sel) at wr_idx, then wr_idx increments.
  - Completion: an accept with wr_idx==N*N-1 sets shadow_full=1 on the next clk.
  - If ld_last differs from (wr_idx==N*N-1) on an accept, load_err=1 (sticky).
  - An early ld_last also resets wr_idx to 0 and the partial matrix is discarded.
  - A missing ld_last on element N*N-1 completes the matrix anyway.
- Swap:
  - Condition: clk_en=1 and rising edge of vblank_in (registered previous value 0, current value 1) and shadow_full=1 (registered value).
  - Action: toggle disp_sel, clear shadow_full, wr_idx=0, pulse frame_swap for one clk.
  - If the matrix completes in the same clk as the vblank edge, no swap occurs that frame; the swap happens at the next vblank edge.
  - If shadow_full=0 at the vblank edge, the current bank is held and redisplayed.
- Pixel pipeline: 2 clk_en stages, latency 2 enabled cycles for RGB and for both syncs. Holds all state when clk_en=0.
  - S1 registers:
    - col = largest c with h_count >= c*CELL_W, clamped to N-1; row likewise from v_count and CELL_H
    - grid = (h_count == c*CELL_W for any c) or (v_count == r*CELL_H for any r)
    - blank = hblank_in | vblank_in
    - hsync, vsync
  - Compare-based only; no dividers.
  - S2 registers:
    - elem = display bank [row*N+col]
    - grid, blank, hsync, vsync delayed one more stage
  - Output colour:
    - blank: RGB = 0
    - else grid: F,F,F
    - else elem==0: R=0, G=0, B=2
    - else: R=G=B=elem[DATA_W-1 -: 4]
- Counter values beyond the visible area only affect blanked pixels, so clamping is safe.

Decomposition:
- Shared package vga_pkg holds:
  - the 640x480@60 timing constants, shared with the horizontal and vertical counters
  - N, CELL_W, CELL_H, DATA_W
  - RGB width 4
  - colour constants GRID_RGB=FFF and ZERO_RGB=002
- One sub-module: matrix_pingpong_buf, containing the load port, both banks, disp_sel, shadow_full, the swap logic and one combinational read port (rd_row, rd_col -> rd_data).
- The top level keeps the S1/S2 pipeline and the colour mapping.

Test Plan:
- Reset release with no load: full frame gives grid pixels FFF, elsewhere RGB 002. Syncs equal the inputs delayed by 2 clk_en; blanked RGB is 0.
- Load elements 0x10..0x1F with ld_last on the 16th, mid-frame: display is unchanged until the vblank rising edge. Then frame_swap pulses once and pixel (h=200, v=130) shows RGB 111 (element 5=0x15). ld_ready is 0 from full until the swap.
- Final accept in the same clk as the vblank edge: no swap that frame; frame_swap pulses at the next frame's vblank edge.
- ld_last on element 7: load_err=1, wr_idx returns to 0. A following 16-element load completes and swaps normally; load_err stays 1.
- clk_en toggling 1-in-4: output changes only on enabled cycles; latency is exactly 2 enabled cycles.
- Reset asserted mid-load and mid-frame: outputs immediately go to reset values; after release, 0x002 fill and no frame_swap until a new matrix is loaded.
